instr_encoder_loader: RTL and testbench

- Inverse of the instruction field decoder: takes decoded MIPS fields (format, opcode, rs, rt, rd, shamt, funct, imm, jaddress) and packs them into 32-bit R/I/J instruction words.
- Writes each packed word sequentially into instruction memory through a synchronous write port.
- Used by the test infrastructure and the boot path to load programs before the CPU is released from reset.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/instr_pack.sv | 47 ++++
 rtl/instr_encoder_loader.sv | 125 ++++++++++++
 tb/tb_instr_encoder_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS field encoder/loader and related benches.
//   FMT_*    : instruction format codes carried on the fmt bus
//   *_LSB/MSB: bit positions of the fixed instruction fields
//   state_t  : loader sequencing states
package cpu_pkg;

  localparam logic [1:0] FMT_R   = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_J   = 2'd2;
  localparam logic [1:0] FMT_BAD = 2'd3;

  localparam int OP_MSB = 31;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int SH_LSB = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: decoded MIPS fields + format -> 32-bit instruction word.
//   fmt                  : 0=R, 1=I, 2=J, 3=illegal
//   opcode..jaddress     : decoded fields; those unused by fmt are ignored
//   word                 : packed instruction (0 / NOP for illegal fmt)
//   bad                  : high when fmt is illegal
module instr_pack (
  input  logic [1:0]  fmt,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] jaddress,
  output logic [31:0] word,
  output logic        bad
);
  import cpu_pkg::*;

  always_comb begin
    word = '0;
    bad  = 1'b0;
    case (fmt)
      FMT_R: begin
        word[OP_MSB -: 6] = opcode;
        word[RS_LSB +: 5] = rs;
        word[RT_LSB +: 5] = rt;
        word[RD_LSB +: 5] = rd;
        word[SH_LSB +: 5] = shamt;
        word[5:0]         = funct;
      end
      FMT_I: begin
        word[OP_MSB -: 6] = opcode;
        word[RS_LSB +: 5] = rs;
        word[RT_LSB +: 5] = rt;
        word[15:0]        = imm;
      end
      FMT_J: begin
        word[OP_MSB -: 6] = opcode;
        word[25:0]        = jaddress;
      end
      default: bad = 1'b1;  // illegal format loads a NOP
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: packs decoded field bundles into instruction words and
// writes them sequentially into instruction memory.
//   clk, rst_n           : clock, async active-low reset
//   start                : open a load session (IDLE or DONE only)
//   in_valid/in_ready    : field bundle handshake; last marks final bundle
//   fmt..jaddress        : decoded instruction fields
//   imem_we/addr/wdata   : registered memory write port, one cycle after accept
//   busy, done           : session status
//   count                : words written this session (saturates at 2^ADDR_W)
//   bad_fmt, overflow    : sticky session error flags
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | after reset, waiting for start
// LOAD    | accepting bundles and writing words
// DONE    | program loaded (last seen or memory overflow)
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       jaddress,
  input  logic              last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              bad_fmt,
  output logic              overflow
);
  import cpu_pkg::*;

  localparam logic [ADDR_W:0]   CAP  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t      state, state_nxt;
  logic        accept;
  logic        restart;
  logic        over_hit;
  logic [31:0] pack_word;
  logic        pack_bad;

  instr_pack u_pack (
    .fmt      (fmt),
    .opcode   (opcode),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .shamt    (shamt),
    .funct    (funct),
    .imm      (imm),
    .jaddress (jaddress),
    .word     (pack_word),
    .bad      (pack_bad)
  );

  assign accept   = in_valid && in_ready;
  assign restart  = start && (state == ST_IDLE || state == ST_DONE);
  assign over_hit = (state == ST_LOAD) && in_valid && (count == CAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: if ((accept && last) || over_hit) state_nxt = ST_DONE;
      ST_DONE: if (start) state_nxt = ST_LOAD;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // in_ready must not depend on in_valid to keep the handshake loop-free.
  always_comb begin
    busy     = (state == ST_LOAD);
    done     = (state == ST_DONE);
    in_ready = (state == ST_LOAD) && (count < CAP);
  end

  // Write port and session bookkeeping. The write is registered so the packed
  // word, its address and the strobe all appear together one cycle after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we    <= 1'b0;
      imem_addr  <= BASE;
      imem_wdata <= '0;
      count      <= '0;
      bad_fmt    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      imem_we <= accept;
      if (accept) begin
        imem_wdata <= pack_word;
        imem_addr  <= BASE + count[ADDR_W-1:0];  // wraps modulo 2^ADDR_W
        count      <= count + 1'b1;
        if (pack_bad) bad_fmt <= 1'b1;
      end
      if (over_hit) overflow <= 1'b1;
      if (restart) begin
        count     <= '0;
        bad_fmt   <= 1'b0;
        overflow  <= 1'b0;
        imem_addr <= BASE;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start_s = 1'b0;
  logic        in_valid = 1'b0;
  logic        last = 1'b0;
  logic [1:0]  fmt = '0;
  logic [5:0]  opcode = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [5:0]  funct = '0;
  logic [15:0] imm = '0;
  logic [25:0] jaddress = '0;

  // main instance, ADDR_W=8
  logic        in_ready, imem_we, busy, done, bad_fmt, overflow;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  count;

  // small instance, ADDR_W=2, for overflow
  logic        in_ready_s, imem_we_s, busy_s, done_s, bad_fmt_s, overflow_s;
  logic [1:0]  imem_addr_s;
  logic [31:0] imem_wdata_s;
  logic [2:0]  count_s;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_m    = 0;
  int exp_s    = 0;
  logic [39:0] q_m[$];
  logic [39:0] q_s[$];

  instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm(imm), .jaddress(jaddress), .last(last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .count(count), .bad_fmt(bad_fmt),
    .overflow(overflow)
  );

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .in_valid(in_valid), .in_ready(in_ready_s),
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm(imm), .jaddress(jaddress), .last(last), .imem_we(imem_we_s), .imem_addr(imem_addr_s),
    .imem_wdata(imem_wdata_s), .busy(busy_s), .done(done_s), .count(count_s), .bad_fmt(bad_fmt_s),
    .overflow(overflow_s)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] enc(input logic [1:0] f, input logic [5:0] op,
      input logic [4:0] s, input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
      input logic [5:0] fn, input logic [15:0] im, input logic [25:0] ja);
    case (f)
      2'd0:    return {op, s, t, d, sh, fn};
      2'd1:    return {op, s, t, im};
      2'd2:    return {op, ja};
      default: return 32'h0;
    endcase
  endfunction

  // scoreboards: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    logic [39:0] e;
    if (imem_we) begin
      n_checks++;
      if (q_m.size() == 0)
        $display("FAIL main_write: unexpected write addr=%0h data=%08h, required no write", imem_addr, imem_wdata);
      else begin
        e = q_m.pop_front();
        if ({imem_addr, imem_wdata} !== e)
          $display("FAIL main_write: got addr=%0h data=%08h, required addr=%0h data=%08h", imem_addr, imem_wdata, e[39:32], e[31:0]);
        else n_pass++;
      end
    end
  end

  always @(negedge clk) begin
    logic [39:0] e;
    if (imem_we_s) begin
      n_checks++;
      if (q_s.size() == 0)
        $display("FAIL small_write: unexpected write addr=%0h data=%08h, required no write", imem_addr_s, imem_wdata_s);
      else begin
        e = q_s.pop_front();
        if ({6'b0, imem_addr_s, imem_wdata_s} !== e)
          $display("FAIL small_write: got addr=%0h data=%08h, required addr=%0h data=%08h", imem_addr_s, imem_wdata_s, e[39:32], e[31:0]);
        else n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit tgt);
    if (tgt) start_s = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0;
    start_s = 1'b0;
    if (tgt) exp_s = 0; else exp_m = 0;
  endtask

  // drive one bundle for one edge; acc says whether the bench expects acceptance
  task automatic send(input bit tgt, input logic [1:0] f, input logic [5:0] op,
      input logic [4:0] s, input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
      input logic [5:0] fn, input logic [15:0] im, input logic [25:0] ja,
      input logic l, input bit acc, input logic [31:0] exp_word);
    fmt = f; opcode = op; rs = s; rt = t; rd = d; shamt = sh; funct = fn;
    imm = im; jaddress = ja; last = l; in_valid = 1'b1;
    if (acc) begin
      if (tgt) begin q_s.push_back({8'(exp_s % 4), exp_word}); exp_s++; end
      else     begin q_m.push_back({8'(exp_m % 256), exp_word}); exp_m++; end
    end
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    last = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if ({imem_we, in_ready, busy, done, bad_fmt, overflow} !== 6'b0)
      $display("FAIL reset_flags: got %b, required 000000", {imem_we, in_ready, busy, done, bad_fmt, overflow}); else n_pass++;
    n_checks++; if (imem_addr !== 8'h00) $display("FAIL reset_addr: got %0h, required 0", imem_addr); else n_pass++;
    n_checks++; if (imem_wdata !== 32'h0) $display("FAIL reset_wdata: got %08h, required 0", imem_wdata); else n_pass++;
    n_checks++; if (count !== 9'd0) $display("FAIL reset_count: got %0d, required 0", count); else n_pass++;
    #1 rst_n = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b0) $display("FAIL idle_ready: got %b, required 0", in_ready); else n_pass++;
  endtask

  task automatic test_r_type();
    pulse_start(0);
    n_checks++; if ({busy, in_ready} !== 2'b11) $display("FAIL start_busy_ready: got %b, required 11", {busy, in_ready}); else n_pass++;
    send(0, 2'd0, 6'h00, 5'd17, 5'd18, 5'd8, 5'd0, 6'h20, 16'h1234, 26'h0, 1'b0, 1'b1, 32'h02324020);
    send(0, 2'd0, 6'h00, 5'd17, 5'd18, 5'd8, 5'd0, 6'h2A, 16'h5678, 26'h0, 1'b1, 1'b1, 32'h0232402A);
    idle(2);
    n_checks++; if ({done, busy, in_ready} !== 3'b100) $display("FAIL rtype_status: got done,busy,ready=%b, required 100", {done, busy, in_ready}); else n_pass++;
    n_checks++; if (count !== 9'd2) $display("FAIL rtype_count: got %0d, required 2", count); else n_pass++;
  endtask

  task automatic test_ij();
    pulse_start(0);
    n_checks++; if (imem_we !== 1'b0) $display("FAIL ij_no_early_write: got %b, required 0", imem_we); else n_pass++;
    send(0, 2'd1, 6'h23, 5'd29, 5'd8, 5'd31, 5'd7, 6'h3F, 16'hFFFC, 26'h3FFFFFF, 1'b0, 1'b1, 32'h8FA8FFFC);
    n_checks++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 8'h00, 32'h8FA8FFFC})
      $display("FAIL ij_lw_latency: got we=%b addr=%0h data=%08h, required we=1 addr=0 data=8fa8fffc", imem_we, imem_addr, imem_wdata); else n_pass++;
    send(0, 2'd2, 6'h02, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h0000040, 1'b1, 1'b1, 32'h08000040);
    n_checks++; if ({imem_we, imem_addr} !== {1'b1, 8'h01})
      $display("FAIL ij_j_latency: got we=%b addr=%0h, required we=1 addr=1", imem_we, imem_addr); else n_pass++;
    idle(1);
    n_checks++; if ({done, imem_we} !== 2'b10) $display("FAIL ij_done: got done,we=%b, required 10", {done, imem_we}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    pulse_start(0);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) start = 1'b1;  // ignored while loading
      send(0, 2'd0, 6'(k), 5'(k + 1), 5'(k + 2), 5'(k), 5'(k), 6'(k + 8), 16'h0, 26'h0, 1'b0, 1'b1,
           enc(2'd0, 6'(k), 5'(k + 1), 5'(k + 2), 5'(k), 5'(k), 6'(k + 8), 16'h0, 26'h0));
      start = 1'b0;
      n_checks++; if ({imem_we, imem_addr} !== {1'b1, 8'(k)})
        $display("FAIL b2b_pulse%0d: got we=%b addr=%0h, required we=1 addr=%0h", k, imem_we, imem_addr, k); else n_pass++;
    end
    for (int k = 0; k < 2; k++) begin
      idle(1);
      n_checks++; if (imem_we !== 1'b0) $display("FAIL stall%0d_we: got %b, required 0", k, imem_we); else n_pass++;
    end
    send(0, 2'd1, 6'h08, 5'd3, 5'd4, 5'd0, 5'd0, 6'h0, 16'h00AA, 26'h0, 1'b1, 1'b1,
         enc(2'd1, 6'h08, 5'd3, 5'd4, 5'd0, 5'd0, 6'h0, 16'h00AA, 26'h0));
    n_checks++; if ({imem_we, imem_addr} !== {1'b1, 8'h04})
      $display("FAIL b2b_resume: got we=%b addr=%0h, required we=1 addr=4", imem_we, imem_addr); else n_pass++;
    idle(1);
    n_checks++; if (count !== 9'd5) $display("FAIL b2b_count: got %0d, required 5", count); else n_pass++;
  endtask

  task automatic test_bad_fmt_restart();
    pulse_start(0);
    send(0, 2'd3, 6'h3F, 5'd9, 5'd9, 5'd9, 5'd9, 6'h3F, 16'hBEEF, 26'h1234567, 1'b0, 1'b1, 32'h0);
    n_checks++; if (bad_fmt !== 1'b1) $display("FAIL bad_fmt_set: got %b, required 1", bad_fmt); else n_pass++;
    send(0, 2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd4, 6'h00, 16'h0, 26'h0, 1'b1, 1'b1,
         enc(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd4, 6'h00, 16'h0, 26'h0));
    idle(1);
    n_checks++; if ({done, bad_fmt, count} !== {2'b11, 9'd2})
      $display("FAIL bad_fmt_done: got done=%b bad=%b count=%0d, required 1 1 2", done, bad_fmt, count); else n_pass++;
    pulse_start(0);
    n_checks++; if ({busy, done, bad_fmt, overflow, count} !== {4'b1000, 9'd0})
      $display("FAIL restart_clear: got busy=%b done=%b bad=%b ovf=%b count=%0d, required 1 0 0 0 0", busy, done, bad_fmt, overflow, count); else n_pass++;
    send(0, 2'd2, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h2ABCDEF, 1'b1, 1'b1, 32'h0EABCDEF);
    n_checks++; if ({imem_we, imem_addr} !== {1'b1, 8'h00})
      $display("FAIL restart_base: got we=%b addr=%0h, required we=1 addr=0", imem_we, imem_addr); else n_pass++;
    idle(1);
  endtask

  task automatic test_overflow();
    pulse_start(1);
    for (int k = 0; k < 4; k++)
      send(1, 2'd1, 6'(k + 1), 5'(k), 5'(k + 4), 5'd0, 5'd0, 6'h0, 16'(k * 16'h1111), 26'h0, 1'b0, 1'b1,
           enc(2'd1, 6'(k + 1), 5'(k), 5'(k + 4), 5'd0, 5'd0, 6'h0, 16'(k * 16'h1111), 26'h0));
    n_checks++; if ({in_ready_s, overflow_s, busy_s, count_s} !== {3'b001, 3'd4})
      $display("FAIL ovf_full: got ready=%b ovf=%b busy=%b count=%0d, required 0 0 1 4", in_ready_s, overflow_s, busy_s, count_s); else n_pass++;
    send(1, 2'd1, 6'h05, 5'd5, 5'd5, 5'd0, 5'd0, 6'h0, 16'hDEAD, 26'h0, 1'b0, 1'b0, 32'h0);
    n_checks++; if ({overflow_s, done_s, imem_we_s} !== 3'b110)
      $display("FAIL ovf_set: got ovf=%b done=%b we=%b, required 1 1 0", overflow_s, done_s, imem_we_s); else n_pass++;
    idle(2);
    n_checks++; if ({done_s, overflow_s, count_s} !== {2'b11, 3'd4})
      $display("FAIL ovf_hold: got done=%b ovf=%b count=%0d, required 1 1 4", done_s, overflow_s, count_s); else n_pass++;
  endtask

  task automatic test_async_reset();
    pulse_start(0);
    send(0, 2'd3, 6'h0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 1'b0, 1'b1, 32'h0);
    fmt = 2'd0; opcode = 6'h0; rs = 5'd5; rt = 5'd6; rd = 5'd7; funct = 6'h21; last = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #2;
    n_checks++; if (imem_we !== 1'b1) $display("FAIL inflight_we: got %b, required 1", imem_we); else n_pass++;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++; if ({imem_we, in_ready, busy, done, bad_fmt, overflow} !== 6'b0)
      $display("FAIL midreset_flags: got %b, required 000000", {imem_we, in_ready, busy, done, bad_fmt, overflow}); else n_pass++;
    n_checks++; if ({imem_addr, imem_wdata, count} !== {8'h00, 32'h0, 9'd0})
      $display("FAIL midreset_regs: got addr=%0h data=%08h count=%0d, required 0 0 0", imem_addr, imem_wdata, count); else n_pass++;
    #3 rst_n = 1'b1;
    tick();
    n_checks++; if ({busy, done, in_ready, imem_we} !== 4'b0)
      $display("FAIL postreset_idle: got busy,done,ready,we=%b, required 0000", {busy, done, in_ready, imem_we}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_ij();
    test_back_to_back();
    test_bad_fmt_restart();
    test_overflow();
    test_async_reset();
    idle(2);
    n_checks++; if (q_m.size() != 0) $display("FAIL main_pending: %0d writes missing, required 0", q_m.size()); else n_pass++;
    n_checks++; if (q_s.size() != 0) $display("FAIL small_pending: %0d writes missing, required 0", q_s.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
